bp_bht: RTL and testbench

- Parametrised successor of the fixed PC+4 predictor; sits between instruction cache and IF.
- Partially decodes each fetched instruction and predicts the next fetch PC.
- Prediction rules: JAL is always taken; conditional branches use a table of 2-bit saturating counters indexed by PC; everything else falls through to PC+4.
- Branch unit trains the table on resolution.

---
 rtl/bp_bht_pkg.sv | 36 +++
 rtl/bp_imm_dec.sv | 35 +++
 rtl/bp_bht.sv | 106 ++++++++++
 tb/tb_bp_bht.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_bht_pkg.sv
// ============================================================================
// Module   : bp_bht_pkg
// Brief    : Shared opcodes, counter encodings and helpers for the BHT predictor
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bp_bht_pkg;

    localparam int INS_DAT_W = 32;
    localparam int REG_DAT_W = 32;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;

    // Saturating 2-bit counter step.
    function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
        if (taken) begin
            return (cnt == ST) ? ST : cnt + 2'd1;
        end
        return (cnt == SNT) ? SNT : cnt - 2'd1;
    endfunction

    function automatic logic cnt_taken(input logic [1:0] cnt);
        return cnt >= WT;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bp_imm_dec.sv
// ============================================================================
// Module   : bp_imm_dec
// Brief    : Partial decode of JAL/BRANCH plus sign-extended J/B immediates
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_imm_dec
    import bp_bht_pkg::*;
#(
    parameter int INS_W = INS_DAT_W,
    parameter int REG_W = REG_DAT_W
) (
    input  logic [INS_W-1:0] ins,
    output logic             is_jal,
    output logic             is_br,
    output logic [REG_W-1:0] imm_j,
    output logic [REG_W-1:0] imm_b
);

    logic [20:0] w_imm_j;
    logic [12:0] w_imm_b;

    assign is_jal  = (ins[6:0] == OPC_JAL);
    assign is_br   = (ins[6:0] == OPC_BRANCH);

    assign w_imm_j = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    assign w_imm_b = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};

    assign imm_j   = {{(REG_W-21){w_imm_j[20]}}, w_imm_j};
    assign imm_b   = {{(REG_W-13){w_imm_b[12]}}, w_imm_b};

endmodule

`default_nettype wire

// File: rtl/bp_bht.sv
// ============================================================================
// Module   : bp_bht
// Brief    : Next-PC predictor: JAL always taken, branches via 2-bit counter table
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_bht
    import bp_bht_pkg::*;
#(
    parameter int         REG_W   = REG_DAT_W,
    parameter int         INS_W   = INS_DAT_W,
    parameter int         IDX_W   = 8,
    parameter logic [1:0] CNT_RST = WNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             iIC_En,
    input  logic [INS_W-1:0] iIC_Ins,
    input  logic [REG_W-1:0] iIF_Pc,
    output logic             oIF_En,
    output logic [REG_W-1:0] oIF_Pjt,
    output logic             oIF_Taken,
    input  logic             iBU_En,
    input  logic [REG_W-1:0] iBU_Pc,
    input  logic             iBU_Taken
);

    localparam int N_ENT = 2 ** IDX_W;

    logic [1:0]       r_cnt [N_ENT];
    logic             r_if_en;
    logic [REG_W-1:0] r_pjt;
    logic             r_taken;

    logic             w_is_jal;
    logic             w_is_br;
    logic [REG_W-1:0] w_imm_j;
    logic [REG_W-1:0] w_imm_b;
    logic [IDX_W-1:0] w_fetch_idx;
    logic [IDX_W-1:0] w_bu_idx;
    logic [REG_W-1:0] w_pc_plus4;
    logic [REG_W-1:0] w_nxt_pjt;
    logic             w_nxt_taken;
    logic             w_unused_bu_pc;

    bp_imm_dec #(
        .INS_W (INS_W),
        .REG_W (REG_W)
    ) u_imm_dec (
        .ins    (iIC_Ins),
        .is_jal (w_is_jal),
        .is_br  (w_is_br),
        .imm_j  (w_imm_j),
        .imm_b  (w_imm_b)
    );

    // Untagged table: PCs sharing the index bits share a counter.
    assign w_fetch_idx    = iIF_Pc[IDX_W+1:2];
    assign w_bu_idx       = iBU_Pc[IDX_W+1:2];
    assign w_unused_bu_pc = ^{iBU_Pc[REG_W-1:IDX_W+2], iBU_Pc[1:0]};
    assign w_pc_plus4     = iIF_Pc + REG_W'(4);

    always_comb begin
        w_nxt_pjt   = w_pc_plus4;
        w_nxt_taken = 1'b0;
        if (w_is_jal) begin
            w_nxt_pjt   = iIF_Pc + w_imm_j;
            w_nxt_taken = 1'b1;
        end else if (w_is_br && cnt_taken(r_cnt[w_fetch_idx])) begin
            w_nxt_pjt   = iIF_Pc + w_imm_b;
            w_nxt_taken = 1'b1;
        end
    end

    // The lookup above sees the counter before any same-edge training write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_en <= 1'b0;
            r_pjt   <= '0;
            r_taken <= 1'b0;
            for (int i = 0; i < N_ENT; i++) begin
                r_cnt[i] <= CNT_RST;
            end
        end else begin
            if (iBU_En) begin
                r_cnt[w_bu_idx] <= cnt_next(r_cnt[w_bu_idx], iBU_Taken);
            end
            if (en) begin
                r_if_en <= iIC_En;
                if (iIC_En) begin
                    r_pjt   <= w_nxt_pjt;
                    r_taken <= w_nxt_taken;
                end
            end
        end
    end

    assign oIF_En    = r_if_en;
    assign oIF_Pjt   = r_pjt;
    assign oIF_Taken = r_taken;

endmodule

`default_nettype wire

// File: tb/tb_bp_bht.sv
// ============================================================================
// Module   : tb_bp_bht
// Brief    : Directed and randomized checks of bp_bht against a behavioural model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bp_bht;

    localparam logic [31:0] BEQ16  = 32'h00000863;
    localparam logic [31:0] JALM8  = 32'hFF9FF06F;
    localparam logic [31:0] JALP8  = 32'h0080006F;
    localparam logic [31:0] JALR0  = 32'h00008067;
    localparam logic [31:0] ADDI0  = 32'h00000013;

    logic        clk;
    logic        rst;
    logic        en;
    logic        iIC_En;
    logic [31:0] iIC_Ins;
    logic [31:0] iIF_Pc;
    logic        oIF_En;
    logic [31:0] oIF_Pjt;
    logic        oIF_Taken;
    logic        iBU_En;
    logic [31:0] iBU_Pc;
    logic        iBU_Taken;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic        m_en;
    logic [31:0] m_pjt;
    logic        m_taken;
    int          m_cnt [256];

    bp_bht dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .iIC_En    (iIC_En),
        .iIC_Ins   (iIC_Ins),
        .iIF_Pc    (iIF_Pc),
        .oIF_En    (oIF_En),
        .oIF_Pjt   (oIF_Pjt),
        .oIF_Taken (oIF_Taken),
        .iBU_En    (iBU_En),
        .iBU_Pc    (iBU_Pc),
        .iBU_Taken (iBU_Taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % 256);
    endfunction

    function automatic void model_predict(input logic [31:0] ins, input logic [31:0] pc,
                                          output logic [31:0] pjt, output logic tk);
        longint imm;
        logic [31:0] opc;
        opc = ins & 32'h7F;
        pjt = pc + 32'd4;
        tk  = 1'b0;
        if (opc == 32'h6F) begin
            imm = ((ins >> 31) & 1) * (1 << 20) + ((ins >> 12) & 255) * (1 << 12)
                + ((ins >> 20) & 1) * (1 << 11) + ((ins >> 21) & 1023) * 2;
            if (imm >= (1 << 20)) imm = imm - (1 << 21);
            pjt = 32'(longint'(pc) + imm);
            tk  = 1'b1;
        end else if (opc == 32'h63 && m_cnt[idx_of(pc)] >= 2) begin
            imm = ((ins >> 31) & 1) * 4096 + ((ins >> 7) & 1) * 2048
                + ((ins >> 25) & 63) * 32 + ((ins >> 8) & 15) * 2;
            if (imm >= 4096) imm = imm - 8192;
            pjt = 32'(longint'(pc) + imm);
            tk  = 1'b1;
        end
    endfunction

    task automatic drive(input logic d_en, input logic d_ic, input logic [31:0] d_ins,
                         input logic [31:0] d_pc, input logic d_bu, input logic [31:0] d_bpc,
                         input logic d_bt);
        en = d_en; iIC_En = d_ic; iIC_Ins = d_ins; iIF_Pc = d_pc;
        iBU_En = d_bu; iBU_Pc = d_bpc; iBU_Taken = d_bt;
    endtask

    // Advance the model with the currently driven inputs, then one clock edge.
    task automatic cycle();
        logic [31:0] n_pjt;
        logic        n_tk;
        if (rst) begin
            m_en = 1'b0; m_pjt = '0; m_taken = 1'b0;
            for (int i = 0; i < 256; i++) m_cnt[i] = 1;
        end else begin
            if (en) begin
                m_en = iIC_En;
                if (iIC_En) begin
                    model_predict(iIC_Ins, iIF_Pc, n_pjt, n_tk);
                    m_pjt = n_pjt; m_taken = n_tk;
                end
            end
            if (iBU_En) begin
                if (iBU_Taken) m_cnt[idx_of(iBU_Pc)] = (m_cnt[idx_of(iBU_Pc)] == 3) ? 3 : m_cnt[idx_of(iBU_Pc)] + 1;
                else           m_cnt[idx_of(iBU_Pc)] = (m_cnt[idx_of(iBU_Pc)] == 0) ? 0 : m_cnt[idx_of(iBU_Pc)] - 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1, 1, JALM8, 32'h200, 0, 0, 0);
        cycle();
        cycle();
        checks++;
        if (oIF_En !== 1'b0 || oIF_Pjt !== 32'h0 || oIF_Taken !== 1'b0) begin
            errors++;
            $display("FAIL reset: got en=%0b pjt=%h tk=%0b, want 0/00000000/0", oIF_En, oIF_Pjt, oIF_Taken);
        end
        rst = 1'b0;
    endtask

    task automatic test_branch_train();
        drive(1, 1, BEQ16, 32'h100, 0, 0, 0);
        cycle();
        checks++;
        if (oIF_En !== 1'b1 || oIF_Pjt !== 32'h104 || oIF_Taken !== 1'b0) begin
            errors++;
            $display("FAIL br_initial: got en=%0b pjt=%h tk=%0b, want 1/00000104/0", oIF_En, oIF_Pjt, oIF_Taken);
        end
        drive(1, 0, BEQ16, 32'h100, 1, 32'h100, 1);
        cycle();
        checks++;
        if (oIF_En !== 1'b0 || oIF_Pjt !== 32'h104 || oIF_Taken !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: got en=%0b pjt=%h tk=%0b, want 0/00000104/0", oIF_En, oIF_Pjt, oIF_Taken);
        end
        cycle();
        cycle();                         // extra taken at ST must saturate
        drive(1, 1, BEQ16, 32'h100, 0, 0, 0);
        cycle();
        checks++;
        if (oIF_En !== 1'b1 || oIF_Pjt !== 32'h110 || oIF_Taken !== 1'b1) begin
            errors++;
            $display("FAIL br_trained: got en=%0b pjt=%h tk=%0b, want 1/00000110/1", oIF_En, oIF_Pjt, oIF_Taken);
        end
        drive(1, 0, BEQ16, 32'h100, 1, 32'h100, 0);
        for (int i = 0; i < 4; i++) cycle();
        drive(1, 1, BEQ16, 32'h100, 0, 0, 0);
        cycle();
        checks++;
        if (oIF_En !== 1'b1 || oIF_Pjt !== 32'h104 || oIF_Taken !== 1'b0) begin
            errors++;
            $display("FAIL br_sat_low: got en=%0b pjt=%h tk=%0b, want 1/00000104/0", oIF_En, oIF_Pjt, oIF_Taken);
        end
    endtask

    task automatic test_jal_jalr();
        drive(1, 1, JALM8, 32'h200, 0, 0, 0);
        cycle();
        checks++;
        if (oIF_En !== 1'b1 || oIF_Pjt !== 32'h1F8 || oIF_Taken !== 1'b1) begin
            errors++;
            $display("FAIL jal_neg: got en=%0b pjt=%h tk=%0b, want 1/000001f8/1", oIF_En, oIF_Pjt, oIF_Taken);
        end
        drive(1, 1, JALR0, 32'h200, 0, 0, 0);
        cycle();
        checks++;
        if (oIF_En !== 1'b1 || oIF_Pjt !== 32'h204 || oIF_Taken !== 1'b0) begin
            errors++;
            $display("FAIL jalr: got en=%0b pjt=%h tk=%0b, want 1/00000204/0", oIF_En, oIF_Pjt, oIF_Taken);
        end
        drive(1, 1, ADDI0, 32'h200, 0, 0, 0);
        cycle();
        checks++;
        if (oIF_En !== 1'b1 || oIF_Pjt !== 32'h204 || oIF_Taken !== 1'b0) begin
            errors++;
            $display("FAIL addi: got en=%0b pjt=%h tk=%0b, want 1/00000204/0", oIF_En, oIF_Pjt, oIF_Taken);
        end
    endtask

    task automatic test_wrap_alias();
        drive(1, 1, JALP8, 32'hFFFFFFFC, 0, 0, 0);
        cycle();
        checks++;
        if (oIF_En !== 1'b1 || oIF_Pjt !== 32'h4 || oIF_Taken !== 1'b1) begin
            errors++;
            $display("FAIL jal_wrap: got en=%0b pjt=%h tk=%0b, want 1/00000004/1", oIF_En, oIF_Pjt, oIF_Taken);
        end
        drive(1, 1, BEQ16, 32'h500, 0, 0, 0);
        cycle();
        checks++;
        if (oIF_Pjt !== 32'h504 || oIF_Taken !== 1'b0) begin
            errors++;
            $display("FAIL alias_before: got pjt=%h tk=%0b, want 00000504/0", oIF_Pjt, oIF_Taken);
        end
        drive(1, 0, BEQ16, 32'h500, 1, 32'h100, 1);
        cycle();
        cycle();
        drive(1, 1, BEQ16, 32'h500, 0, 0, 0);
        cycle();
        checks++;
        if (oIF_Pjt !== 32'h510 || oIF_Taken !== 1'b1) begin
            errors++;
            $display("FAIL alias_after: got pjt=%h tk=%0b, want 00000510/1", oIF_Pjt, oIF_Taken);
        end
    endtask

    task automatic test_same_cycle();
        drive(1, 0, BEQ16, 32'h100, 1, 32'h100, 0);     // counter 2 -> 1
        cycle();
        drive(1, 1, BEQ16, 32'h100, 1, 32'h100, 1);     // lookup 1, write 2
        cycle();
        checks++;
        if (oIF_En !== 1'b1 || oIF_Pjt !== 32'h104 || oIF_Taken !== 1'b0) begin
            errors++;
            $display("FAIL rbw_first: got en=%0b pjt=%h tk=%0b, want 1/00000104/0", oIF_En, oIF_Pjt, oIF_Taken);
        end
        drive(1, 1, BEQ16, 32'h100, 0, 0, 0);
        cycle();
        checks++;
        if (oIF_En !== 1'b1 || oIF_Pjt !== 32'h110 || oIF_Taken !== 1'b1) begin
            errors++;
            $display("FAIL rbw_second: got en=%0b pjt=%h tk=%0b, want 1/00000110/1", oIF_En, oIF_Pjt, oIF_Taken);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, JALM8, 32'h200, (i == 0), 32'h300, 1);
            cycle();
            checks++;
            if (oIF_En !== 1'b1 || oIF_Pjt !== 32'h110 || oIF_Taken !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got en=%0b pjt=%h tk=%0b, want 1/00000110/1",
                         i, oIF_En, oIF_Pjt, oIF_Taken);
            end
        end
        drive(1, 1, BEQ16, 32'h300, 0, 0, 0);
        cycle();
        checks++;
        if (oIF_En !== 1'b1 || oIF_Pjt !== 32'h310 || oIF_Taken !== 1'b1) begin
            errors++;
            $display("FAIL stall_update: got en=%0b pjt=%h tk=%0b, want 1/00000310/1", oIF_En, oIF_Pjt, oIF_Taken);
        end
    endtask

    task automatic test_reset_mid();
        drive(1, 1, JALM8, 32'h200, 1, 32'h100, 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checks++;
        if (oIF_En !== 1'b0 || oIF_Pjt !== 32'h0 || oIF_Taken !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: got en=%0b pjt=%h tk=%0b, want 0/00000000/0", oIF_En, oIF_Pjt, oIF_Taken);
        end
        drive(1, 1, BEQ16, 32'h300, 0, 0, 0);
        cycle();
        checks++;
        if (oIF_Pjt !== 32'h304 || oIF_Taken !== 1'b0) begin
            errors++;
            $display("FAIL rst_table: got pjt=%h tk=%0b, want 00000304/0", oIF_Pjt, oIF_Taken);
        end
        drive(1, 1, BEQ16, 32'h100, 1, 32'h100, 1);
        cycle();
        checks++;
        if (oIF_Pjt !== 32'h104 || oIF_Taken !== 1'b0) begin
            errors++;
            $display("FAIL rst_wnt_a: got pjt=%h tk=%0b, want 00000104/0", oIF_Pjt, oIF_Taken);
        end
        drive(1, 1, BEQ16, 32'h100, 0, 0, 0);
        cycle();
        checks++;
        if (oIF_Pjt !== 32'h110 || oIF_Taken !== 1'b1) begin
            errors++;
            $display("FAIL rst_wnt_b: got pjt=%h tk=%0b, want 00000110/1", oIF_Pjt, oIF_Taken);
        end
    endtask

    task automatic test_random();
        logic [31:0] r;
        logic [31:0] ins;
        logic [31:0] pc;
        logic [31:0] bpc;
        for (int n = 0; n < 400; n++) begin
            r = $urandom;
            case ($urandom_range(0, 3))
                0:       ins = {r[31:7], 7'b1100011};
                1:       ins = {r[31:7], 7'b1101111};
                2:       ins = {r[31:7], 7'b1100111};
                default: ins = r;
            endcase
            pc       = $urandom;
            pc[9:2]  = 8'($urandom_range(0, 7));
            bpc      = $urandom;
            bpc[9:2] = 8'($urandom_range(0, 7));
            rst = ($urandom_range(0, 63) == 0);
            drive(($urandom_range(0, 3) != 0), 1'($urandom), ins, pc,
                  1'($urandom), bpc, 1'($urandom));
            cycle();
            checks++;
            if (oIF_En !== m_en || oIF_Pjt !== m_pjt || oIF_Taken !== m_taken) begin
                errors++;
                $display("FAIL random[%0d]: got en=%0b pjt=%h tk=%0b, want %0b/%h/%0b",
                         n, oIF_En, oIF_Pjt, oIF_Taken, m_en, m_pjt, m_taken);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, '0, '0, 0, '0, 0);
        test_reset();
        test_branch_train();
        test_jal_jalr();
        test_wrap_alias();
        test_same_cycle();
        test_stall();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
